// File: rtl/scc_pkg.sv
// Shared constants for the execute/writeback slice: widths, CPSR bit positions
// and ARM-style condition codes.
package scc_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/scc_cond_eval.sv
// Combinational condition-code evaluator: (cond, N/C/Z/V flags) -> taken.
// Kept standalone so the fetch stage can reuse it for early branch resolution.
module scc_cond_eval
    import scc_pkg::*;
(
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);

    logic n, c, z, v;

    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~(c & ~z);
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = ~(~z & (n == v));
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/scc_regfile_wb.sv
// Writeback end of EX: 8x32 register file, CPSR and registered branch resolution.
// Optional macro SCC_WB_BYPASS_EN forwards same-cycle write data and flag updates.
module scc_regfile_wb
    import scc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable,
    input  logic              w_select,
    input  logic [DATA_W-1:0] w_alu,
    input  logic [DATA_W-1:0] w_id,
    input  logic [ADDR_W-1:0] dest_reg,
    input  logic [ADDR_W-1:0] r_addr_0,
    input  logic [ADDR_W-1:0] r_addr_1,
    output logic [DATA_W-1:0] r_val_0,
    output logic [DATA_W-1:0] r_val_1,
    input  logic              flags_we,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [FLAG_W-1:0] cpsr,
    input  logic              b_eval,
    input  logic [3:0]        b_cond,
    output logic              b_valid,
    output logic              b_taken
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] w_data;
    logic [FLAG_W-1:0] cpsr_q;
    logic [FLAG_W-1:0] cpsr_eff;
    logic              cond_taken;

    assign w_data = w_select ? w_id : w_alu;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (w_enable) begin
            regs[dest_reg] <= w_data;
        end
    end

`ifdef SCC_WB_BYPASS_EN
    assign r_val_0  = (w_enable && (dest_reg == r_addr_0)) ? w_data : regs[r_addr_0];
    assign r_val_1  = (w_enable && (dest_reg == r_addr_1)) ? w_data : regs[r_addr_1];
    assign cpsr_eff = flags_we ? flags_in : cpsr_q;
`else
    assign r_val_0  = regs[r_addr_0];
    assign r_val_1  = regs[r_addr_1];
    assign cpsr_eff = cpsr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_q <= '0;
        end else if (flags_we) begin
            cpsr_q <= flags_in;
        end
    end

    assign cpsr = cpsr_q;

    scc_cond_eval u_cond_eval (
        .cond  (b_cond),
        .flags (cpsr_eff),
        .taken (cond_taken)
    );

    // b_eval is a one-cycle request with no backpressure; b_valid is a one-cycle
    // response exactly one edge later, and b_taken is meaningful only while b_valid=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid <= 1'b0;
            b_taken <= 1'b0;
        end else begin
            b_valid <= b_eval;
            b_taken <= b_eval & cond_taken;
        end
    end

endmodule

// File: tb/tb_scc_regfile_wb.sv
// Directed bench for scc_regfile_wb with a behavioural reference model checked every cycle.
// Honours SCC_WB_BYPASS_EN when the same define is given to the bench build.
module tb_scc_regfile_wb;
    import scc_pkg::*;

`ifdef SCC_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              w_enable;
    logic              w_select;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_id;
    logic [ADDR_W-1:0] dest_reg;
    logic [ADDR_W-1:0] r_addr_0;
    logic [ADDR_W-1:0] r_addr_1;
    logic [DATA_W-1:0] r_val_0;
    logic [DATA_W-1:0] r_val_1;
    logic              flags_we;
    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] cpsr;
    logic              b_eval;
    logic [3:0]        b_cond;
    logic              b_valid;
    logic              b_taken;

    int checks   = 0;
    int failures = 0;

    scc_regfile_wb dut (
        .clk      (clk),
        .rst      (rst),
        .w_enable (w_enable),
        .w_select (w_select),
        .w_alu    (w_alu),
        .w_id     (w_id),
        .dest_reg (dest_reg),
        .r_addr_0 (r_addr_0),
        .r_addr_1 (r_addr_1),
        .r_val_0  (r_val_0),
        .r_val_1  (r_val_1),
        .flags_we (flags_we),
        .flags_in (flags_in),
        .cpsr     (cpsr),
        .b_eval   (b_eval),
        .b_cond   (b_cond),
        .b_valid  (b_valid),
        .b_taken  (b_taken)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [FLAG_W-1:0] m_cpsr;
    logic              m_bvalid;
    logic              m_btaken;
    bit                model_ok = 1'b0;

    // Condition codes come in complementary pairs; odd codes negate the even one.
    function automatic bit model_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, c, z, v, base;
        n = f[3]; c = f[2]; z = f[1]; v = f[0];
        case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    always @(posedge clk) begin
        logic [FLAG_W-1:0] eff;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_cpsr   = '0;
            m_bvalid = 1'b0;
            m_btaken = 1'b0;
            model_ok = 1'b1;
        end else begin
            eff      = (BYP && flags_we) ? flags_in : m_cpsr;
            m_bvalid = b_eval;
            m_btaken = b_eval && model_cond(b_cond, eff);
            if (w_enable) m_regs[dest_reg] = w_select ? w_id : w_alu;
            if (flags_we) m_cpsr = flags_in;
        end
    end

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (BYP && w_enable && dest_reg == a) return w_select ? w_id : w_alu;
        return m_regs[a];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_r_val_0", r_val_0, model_read(r_addr_0));
            chk("model_r_val_1", r_val_1, model_read(r_addr_1));
            chk("model_cpsr", {28'd0, cpsr}, {28'd0, m_cpsr});
            chk("model_b_valid", {31'd0, b_valid}, {31'd0, m_bvalid});
            if (m_bvalid) chk("model_b_taken", {31'd0, b_taken}, {31'd0, m_btaken});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_enable = 1'b0; w_select = 1'b0; w_alu = '0; w_id = '0; dest_reg = '0;
        flags_we = 1'b0; flags_in = '0; b_eval = 1'b0; b_cond = '0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_we = 1'b1; flags_in = f;
        tick();
        flags_we = 1'b0;
    endtask

    task automatic branch(input string name, input logic [3:0] code, input bit exp);
        b_eval = 1'b1; b_cond = code;
        tick();
        b_eval = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, b_valid}, 32'd1);
        chk({name, "_taken"}, {31'd0, b_taken}, {31'd0, exp});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        rst = 1'b1; r_addr_0 = '0; r_addr_1 = '0;
        tick();
        rst = 1'b0;

        for (int i = 0; i < NREGS; i++) begin
            r_addr_0 = ADDR_W'(i); r_addr_1 = ADDR_W'(NREGS - 1 - i);
            @(negedge clk);
            chk("reset_r_val_0", r_val_0, 32'd0);
            chk("reset_r_val_1", r_val_1, 32'd0);
            tick();
        end
        chk("reset_cpsr", {28'd0, cpsr}, 32'd0);
        chk("reset_b_valid", {31'd0, b_valid}, 32'd0);

        // ALU-path write, then ID-path overwrite
        w_enable = 1'b1; w_select = 1'b0; w_alu = 32'hDEADBEEF; w_id = 32'h0BAD0BAD; dest_reg = 3'd3;
        tick();
        idle(); r_addr_0 = 3'd3;
        @(negedge clk);
        chk("wr_alu_r3", r_val_0, 32'hDEADBEEF);
        tick();
        w_enable = 1'b1; w_select = 1'b1; w_id = 32'h1234; w_alu = 32'hFFFF_0000; dest_reg = 3'd3;
        tick();
        idle(); r_addr_0 = 3'd3; r_addr_1 = 3'd7;
        @(negedge clk);
        chk("wr_id_r3", r_val_0, 32'h0000_1234);
        chk("r7_untouched", r_val_1, 32'd0);
        tick();

        // Z set: EQ then back-to-back NE
        set_flags(4'b0010);
        b_eval = 1'b1; b_cond = COND_EQ;
        tick();
        b_cond = COND_NE;
        @(negedge clk);
        chk("cpsr_z", {28'd0, cpsr}, 32'h2);
        chk("eq_valid", {31'd0, b_valid}, 32'd1);
        chk("eq_taken", {31'd0, b_taken}, 32'd1);
        tick();
        b_eval = 1'b0;
        @(negedge clk);
        chk("ne_valid", {31'd0, b_valid}, 32'd1);
        chk("ne_taken", {31'd0, b_taken}, 32'd0);
        tick();
        @(negedge clk);
        chk("valid_drops", {31'd0, b_valid}, 32'd0);

        set_flags(4'b1001);
        branch("ge_nv", COND_GE, 1'b1);
        branch("lt_nv", COND_LT, 1'b0);
        branch("gt_nv", COND_GT, 1'b1);
        set_flags(4'b0100);
        branch("hi_c", COND_HI, 1'b1);
        branch("ls_c", COND_LS, 1'b0);
        branch("al_c", COND_AL, 1'b1);
        branch("nv_c", COND_NV, 1'b0);
        tick();

        // same-cycle write/read and flag-update/branch hazards
        w_enable = 1'b1; w_select = 1'b0; w_alu = 32'd5; dest_reg = 3'd2; r_addr_0 = 3'd2;
        @(negedge clk);
        chk("hazard_read_r2", r_val_0, BYP ? 32'd5 : 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("after_write_r2", r_val_0, 32'd5);
        flags_we = 1'b1; flags_in = 4'b0010; b_eval = 1'b1; b_cond = COND_EQ;
        tick();
        idle();
        @(negedge clk);
        chk("hazard_eq_taken", {31'd0, b_taken}, BYP ? 32'd1 : 32'd0);
        chk("hazard_cpsr", {28'd0, cpsr}, 32'h2);
        tick();

        // reset in the middle of a write, flag update and branch request
        rst = 1'b1; w_enable = 1'b1; w_alu = 32'hAA; dest_reg = 3'd6;
        flags_we = 1'b1; flags_in = 4'hF; b_eval = 1'b1; b_cond = COND_AL;
        tick();
        rst = 1'b0; idle(); r_addr_0 = 3'd6; r_addr_1 = 3'd2;
        @(negedge clk);
        chk("rst_mid_r6", r_val_0, 32'd0);
        chk("rst_mid_r2", r_val_1, 32'd0);
        chk("rst_mid_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_mid_cpsr", {28'd0, cpsr}, 32'd0);
        tick();

        // sweep: fill every register and evaluate all conditions under all flag values
        for (int i = 0; i < NREGS; i++) begin
            w_enable = 1'b1; w_select = i[0]; dest_reg = ADDR_W'(i);
            w_alu = 32'h1000_0000 + 32'(i); w_id = 32'h2000_0000 + 32'(i);
            r_addr_0 = ADDR_W'(i); r_addr_1 = ADDR_W'(i + 1);
            tick();
        end
        idle();
        for (int f = 0; f < 16; f++) begin
            flags_we = 1'b1; flags_in = 4'(f);
            for (int c = 0; c < 16; c++) begin
                b_eval = 1'b1; b_cond = 4'(c);
                r_addr_0 = 3'(c); r_addr_1 = 3'(f);
                tick();
                flags_we = 1'b0;
            end
        end
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
